// File: rtl/fc_pkg.sv
// fc_pkg: definitions shared by the FC output stage.
//   state_t      - controller states of fc_act_pack
//   Q_MAX/Q_MIN  - int8 saturation limits
//   *_DEF        - default widths used by the modules
//   lane_strb()  - byte-lane strobe for lanes 0..idx
package fc_pkg;

  localparam int PSUM_W_DEF  = 20;
  localparam int ADDR_W_DEF  = 7;
  localparam int SHIFT_W_DEF = 4;

  localparam int Q_MAX = 127;
  localparam int Q_MIN = -128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FLUSH,
    S_DONE
  } state_t;

  // Strobe with lanes 0..idx set, so a partial final word marks only its filled lanes.
  function automatic logic [3:0] lane_strb(input logic [1:0] idx);
    logic [3:0] s;
    case (idx)
      2'd0:    s = 4'b0001;
      2'd1:    s = 4'b0011;
      2'd2:    s = 4'b0111;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fc_requant.sv
// fc_requant: combinational requantisation of one partial sum to int8.
//   psum    in  PSUM_W   signed partial sum
//   shift   in  SHIFT_W  right-shift amount
//   relu_en in  1        clamp negative inputs to zero
//   q       out 8        saturated int8 result (two's complement bits)
module fc_requant
  import fc_pkg::*;
#(
  parameter int PSUM_W  = PSUM_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic signed [PSUM_W-1:0]  psum,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu_en,
  output logic        [7:0]         q
);

  // One guard bit so adding the rounding half can never overflow.
  localparam logic signed [PSUM_W:0] R_MAX = (PSUM_W+1)'(Q_MAX);
  localparam logic signed [PSUM_W:0] R_MIN = (PSUM_W+1)'(Q_MIN);

  logic signed [PSUM_W:0] y;
  logic signed [PSUM_W:0] half;
  logic signed [PSUM_W:0] sum;
  logic signed [PSUM_W:0] r;

  // Round-half-up: add 2^(shift-1), then arithmetic shift floors toward -inf.
  always_comb begin
    y    = (relu_en && psum[PSUM_W-1]) ? '0 : {psum[PSUM_W-1], psum};
    half = '0;
    sum  = y;
    r    = y;
    if (shift != '0) begin
      half = (PSUM_W+1)'(1) << (shift - SHIFT_W'(1));
      sum  = y + half;
      r    = sum >>> shift;
    end
    if (r > R_MAX)      q = R_MAX[7:0];
    else if (r < R_MIN) q = R_MIN[7:0];
    else                q = r[7:0];
  end

endmodule

// File: rtl/fc_act_pack.sv
// fc_act_pack: FC output stage. Requantises the PE-array result stream to
// int8, packs four results per 32-bit word and writes the output buffer.
//   clk, rst        clock, synchronous active-high reset
//   start_i         arms a new layer; latches shift_i / relu_en_i
//   valid_i/last_i  qualify psum_i; last_i marks the final result
//   obuf_*          output buffer write port (node n in lane n%4)
//   done_o          one-cycle pulse after the final write
//   out_cnt_o       results accepted this layer, saturating at 127
module fc_act_pack
  import fc_pkg::*;
#(
  parameter int PSUM_W  = PSUM_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      relu_en_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  input  logic signed [PSUM_W-1:0]  psum_i,
  output logic                      obuf_wren_o,
  output logic        [ADDR_W-1:0]  obuf_wraddr_o,
  output logic        [31:0]        obuf_wdata_o,
  output logic        [3:0]         obuf_wstrb_o,
  output logic                      done_o,
  output logic        [6:0]         out_cnt_o
);

  state_t state, state_nxt;

  logic [SHIFT_W-1:0] shift_q;
  logic               relu_q;
  logic               accept;
  logic [7:0]         q_comb;

  logic               s1_valid;
  logic               s1_last;
  logic [7:0]         s1_byte;

  logic [1:0]         byte_idx;
  logic [31:0]        pack_q;
  logic [31:0]        full_word;
  logic [ADDR_W-1:0]  addr_q;
  logic               wr_last_q;
  logic [6:0]         out_cnt_q;

  assign accept    = (state == S_COLLECT) && valid_i;
  assign full_word = pack_q | ({24'd0, s1_byte} << {byte_idx, 3'b000});
  assign done_o    = (state == S_DONE);
  assign out_cnt_o = out_cnt_q;

  fc_requant #(
    .PSUM_W  (PSUM_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .psum    (psum_i),
    .shift   (shift_q),
    .relu_en (relu_q),
    .q       (q_comb)
  );

  // Next-state logic. FLUSH waits until the write carrying the last byte
  // has been presented, so done_o lands one cycle after that write.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_i) state_nxt = S_COLLECT;
      S_COLLECT: if (accept && last_i) state_nxt = S_FLUSH;
      S_FLUSH:   if (obuf_wren_o && wr_last_q) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State, requant pipeline register, packer and write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s1_byte       <= '0;
      byte_idx      <= '0;
      pack_q        <= '0;
      addr_q        <= '0;
      wr_last_q     <= 1'b0;
      out_cnt_q     <= '0;
      obuf_wren_o   <= 1'b0;
      obuf_wraddr_o <= '0;
      obuf_wdata_o  <= '0;
      obuf_wstrb_o  <= '0;
    end else begin
      state       <= state_nxt;
      s1_valid    <= accept;
      s1_last     <= accept & last_i;
      s1_byte     <= q_comb;
      obuf_wren_o <= 1'b0;
      wr_last_q   <= 1'b0;

      if (state == S_IDLE && start_i) begin
        shift_q   <= shift_i;
        relu_q    <= relu_en_i;
        addr_q    <= '0;
        byte_idx  <= '0;
        pack_q    <= '0;
        out_cnt_q <= '0;
      end

      if (accept && out_cnt_q != 7'd127) out_cnt_q <= out_cnt_q + 7'd1;

      // Emit on a full word or on the last result; otherwise keep filling.
      if (s1_valid) begin
        if (byte_idx == 2'd3 || s1_last) begin
          obuf_wren_o   <= 1'b1;
          obuf_wraddr_o <= addr_q;
          obuf_wdata_o  <= full_word;
          obuf_wstrb_o  <= lane_strb(byte_idx);
          wr_last_q     <= s1_last;
          addr_q        <= addr_q + ADDR_W'(1);
          byte_idx      <= '0;
          pack_q        <= '0;
        end else begin
          pack_q   <= full_word;
          byte_idx <= byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_act_pack.sv
// tb_fc_act_pack: directed self-checking bench for fc_act_pack.
module tb_fc_act_pack;

  logic               clk;
  logic               rst;
  logic               start_i;
  logic [3:0]         shift_i;
  logic               relu_en_i;
  logic               valid_i;
  logic               last_i;
  logic signed [19:0] psum_i;
  logic               obuf_wren_o;
  logic [6:0]         obuf_wraddr_o;
  logic [31:0]        obuf_wdata_o;
  logic [3:0]         obuf_wstrb_o;
  logic               done_o;
  logic [6:0]         out_cnt_o;

  int nCompared   = 0;
  int nMismatched = 0;

  logic signed [19:0] vec [0:159];

  logic [31:0] capData[$];
  logic [6:0]  capAddr[$];
  logic [3:0]  capStrb[$];
  int doneCount   = 0;
  int cycleNo     = 0;
  int lastWrCycle = 0;
  int doneCycle   = 0;
  int wrBase      = 0;
  int doneBase    = 0;

  fc_act_pack dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .shift_i       (shift_i),
    .relu_en_i     (relu_en_i),
    .valid_i       (valid_i),
    .last_i        (last_i),
    .psum_i        (psum_i),
    .obuf_wren_o   (obuf_wren_o),
    .obuf_wraddr_o (obuf_wraddr_o),
    .obuf_wdata_o  (obuf_wdata_o),
    .obuf_wstrb_o  (obuf_wstrb_o),
    .done_o        (done_o),
    .out_cnt_o     (out_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture writes and done pulses away from the active edge.
  always @(negedge clk) begin
    cycleNo = cycleNo + 1;
    if (obuf_wren_o) begin
      capData.push_back(obuf_wdata_o);
      capAddr.push_back(obuf_wraddr_o);
      capStrb.push_back(obuf_wstrb_o);
      lastWrCycle = cycleNo;
    end
    if (done_o) begin
      doneCount = doneCount + 1;
      doneCycle = cycleNo;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared = nCompared + 1;
    if (obs !== exp) begin
      nMismatched = nMismatched + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs one layer of n results from vec; optional idle gaps and a stray start_i mid-layer.
  task automatic applyStimulus(input logic relu, input logic [3:0] sh, input int n,
                               input bit gaps, input bit midStart);
    int k;
    wrBase   = capData.size();
    doneBase = doneCount;
    @(posedge clk); #1;
    start_i = 1'b1; shift_i = sh; relu_en_i = relu;
    @(posedge clk); #1;
    start_i = 1'b0; shift_i = 4'd0; relu_en_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        valid_i = 1'b0; last_i = 1'b0;
        if (midStart && i == 2) begin
          start_i = 1'b1; shift_i = 4'd5; relu_en_i = 1'b0;
        end
        @(posedge clk); #1;
        start_i = 1'b0; shift_i = 4'd0;
      end
      valid_i = 1'b1; psum_i = vec[i]; last_i = (i == n - 1);
      @(posedge clk); #1;
    end
    valid_i = 1'b0; last_i = 1'b0; psum_i = '0;
    k = 0;
    while (doneCount == doneBase && k < 40) begin
      @(posedge clk);
      k++;
    end
    if (doneCount == doneBase) checkOutput("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input int idx, input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
    if (capData.size() > wrBase + idx) begin
      checkOutput($sformatf("addr[%0d]", idx), 32'(capAddr[wrBase+idx]), 32'(a));
      checkOutput($sformatf("wdata[%0d]", idx), capData[wrBase+idx], d);
      checkOutput($sformatf("wstrb[%0d]", idx), 32'(capStrb[wrBase+idx]), 32'(s));
    end
  endtask

  task automatic checkLayerEnd(input string tag, input int nWrites, input int cnt);
    checkOutput({tag, "_nwrites"}, 32'(capData.size() - wrBase), 32'(nWrites));
    checkOutput({tag, "_ndone"}, 32'(doneCount - doneBase), 32'd1);
    checkOutput({tag, "_done_lag"}, 32'(doneCycle - lastWrCycle), 32'd1);
    checkOutput({tag, "_out_cnt"}, 32'(out_cnt_o), 32'(cnt));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; shift_i = '0; relu_en_i = 1'b0;
    valid_i = 1'b0; last_i = 1'b0; psum_i = '0;
    for (int i = 0; i < 160; i++) vec[i] = 20'sd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wren",   32'(obuf_wren_o), 32'd0);
    checkOutput("rst_wraddr", 32'(obuf_wraddr_o), 32'd0);
    checkOutput("rst_wdata",  obuf_wdata_o, 32'd0);
    checkOutput("rst_wstrb",  32'(obuf_wstrb_o), 32'd0);
    checkOutput("rst_done",   32'(done_o), 32'd0);
    checkOutput("rst_out_cnt", 32'(out_cnt_o), 32'd0);
    rst = 1'b0;

    // Valids before any start must be ignored.
    wrBase = capData.size(); doneBase = doneCount;
    valid_i = 1'b1; last_i = 1'b1; psum_i = 20'sd33;
    repeat (3) @(posedge clk);
    #1;
    valid_i = 1'b0; last_i = 1'b0; psum_i = '0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("prestart_nwrites", 32'(capData.size() - wrBase), 32'd0);
    checkOutput("prestart_ndone", 32'(doneCount - doneBase), 32'd0);
    checkOutput("prestart_out_cnt", 32'(out_cnt_o), 32'd0);

    // Full word, ReLU, no shift.
    vec[0] = 20'sd10; vec[1] = -20'sd5; vec[2] = 20'sd300; vec[3] = 20'sd127;
    applyStimulus(1'b1, 4'd0, 4, 1'b0, 1'b0);
    checkLayerEnd("relu", 1, 4);
    checkWrite(0, 7'd0, 32'h7F7F000A, 4'hF);

    // Same data with gaps and a stray start_i carrying different settings.
    applyStimulus(1'b1, 4'd0, 4, 1'b1, 1'b1);
    checkLayerEnd("gaps", 1, 4);
    checkWrite(0, 7'd0, 32'h7F7F000A, 4'hF);

    // Rounding with negatives kept: 2, -1, 2, -75.
    vec[0] = 20'sd6; vec[1] = -20'sd6; vec[2] = 20'sd7; vec[3] = -20'sd300;
    applyStimulus(1'b0, 4'd2, 4, 1'b0, 1'b0);
    checkLayerEnd("round", 1, 4);
    checkWrite(0, 7'd0, 32'hB502FF02, 4'hF);

    // Reset after three accepted results: nothing written, no done.
    wrBase = capData.size(); doneBase = doneCount;
    @(posedge clk); #1;
    start_i = 1'b1; shift_i = 4'd0; relu_en_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; psum_i = 20'(i + 9);
      @(posedge clk); #1;
    end
    valid_i = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("midrst_nwrites", 32'(capData.size() - wrBase), 32'd0);
    checkOutput("midrst_ndone", 32'(doneCount - doneBase), 32'd0);
    checkOutput("midrst_out_cnt", 32'(out_cnt_o), 32'd0);
    checkOutput("midrst_wdata", obuf_wdata_o, 32'd0);

    // Partial last word after the reset: results 1..5.
    for (int i = 0; i < 5; i++) vec[i] = 20'(i + 1);
    applyStimulus(1'b0, 4'd0, 5, 1'b0, 1'b0);
    checkLayerEnd("partial", 2, 5);
    checkWrite(0, 7'd0, 32'h04030201, 4'hF);
    checkWrite(1, 7'd1, 32'h00000005, 4'h1);

    // Saturation both ways with shift 1.
    vec[0] = 20'sd1000; vec[1] = -20'sd1000;
    applyStimulus(1'b0, 4'd1, 2, 1'b0, 1'b0);
    checkLayerEnd("sat", 1, 2);
    checkWrite(0, 7'd0, 32'h0000807F, 4'h3);

    // Long layer: out_cnt saturates at 127, 130 results give 33 writes.
    for (int i = 0; i < 130; i++) vec[i] = 20'sd1;
    applyStimulus(1'b0, 4'd0, 130, 1'b0, 1'b0);
    checkLayerEnd("long", 33, 127);
    checkWrite(0, 7'd0, 32'h01010101, 4'hF);
    checkWrite(32, 7'd32, 32'h00000101, 4'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
